muldiv_ctrl: RTL
================

// Module: muldiv_ctrl
// PURPOSE
//  Multi-cycle scheduler for HI/LO multiply/divide ops (MULT, MULTU, DIV, DIVU) in the E stage.
//  Accepts one op from E, freezes the pipeline through a stall request until the result is ready,
//  then issues a single HI/LO write strobe.
//  Contains the operand/result registers, an iterative radix-2 restoring divider and a
//  pipelined multiplier path.
//  Sits beside the E-stage ALU; its stall output feeds the hazard unit.
// PARAMETERS
//  WIDTH    32  operand width; HI and LO are each WIDTH bits
//  MUL_LAT  2   cycles spent in MUL state (>=1)
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous reset, active-low
//  startE    in   1      valid mul/div op in E this cycle
//  opE       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  srcaE     in   WIDTH  rs operand (multiplicand / dividend)
//  srcbE     in   WIDTH  rt operand (multiplier / divisor)
//  flushE    in   1      cancel the op in E / abort the op in flight
//  stallmd   out  1      pipeline stall request
//  hilo_we   out  1      one-cycle HI/LO write strobe
//  hi_o      out  WIDTH  HI result (product[2W-1:W] / remainder)
//  lo_o      out  WIDTH  LO result (product[W-1:0] / quotient)
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE; stallmd, hilo_we, hi_o, lo_o, counter and operand registers all 0
//  FSM states: IDLE, MUL, DIV, DONE
//   - IDLE: go = startE & ~flushE.
//       stallmd = go (combinational, same cycle).
//       On go: latch srcaE, srcbE, opE; clear counter; op[1]=0 -> MUL, op[1]=1 -> DIV.
//   - MUL: stallmd=1. Counter runs 1..MUL_LAT; at MUL_LAT -> DONE.
//       Product is the signed (MULT) or unsigned (MULTU) 2W-bit product.
//   - DIV: stallmd=1. Exactly WIDTH iterations, one quotient bit per cycle, MSB first; then -> DONE.
//       Signed: divide |a| by |b|; quotient negated if a[W-1]^b[W-1]; remainder takes the sign of a.
//   - DONE: stallmd=0, hilo_we=1, hi_o/lo_o valid; -> IDLE unconditionally.
//       startE is ignored in DONE (it is still the finishing instruction).
//  Latency, counted from the IDLE cycle with go:
//   - MUL: stall for MUL_LAT+1 cycles; hilo_we in cycle MUL_LAT+1.
//   - DIV: stall for WIDTH+1 cycles; hilo_we in cycle WIDTH+1.
//  Back-to-back ops: a new op may start in the first IDLE cycle after DONE. No overlap.
//  hi_o/lo_o hold their last value outside DONE; they change only on DONE entry.
//  Divide by zero (b==0), signed or unsigned:
//   - no trap, still WIDTH cycles
//   - lo_o = {WIDTH{1'b1}}, hi_o = latched a
//  Overflow: DIV 0x80000000 / -1 gives lo_o=0x80000000, hi_o=0 (magnitude wrap, no trap).
//  flushE in MUL or DIV: abort the op.
//   - next state IDLE, no hilo_we; stallmd drops the next cycle
//   - hi_o/lo_o keep their old values
//  flushE in DONE: the write still happens (the result is committed).
//  Reset mid-operation: immediate IDLE, outputs 0, no write.
// TESTING
//  1. MULT a=-3 (0xFFFFFFFD), b=5 -> stallmd high 3 cycles; hilo_we in cycle 3; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  2. DIVU a=100, b=7 -> stallmd high 33 cycles; hilo_we in cycle 33; lo=14, hi=2.
//  3. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
//  4. DIVU a=0x1234, b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x1234.
//  5. Flush/reset: flushE at DIV cycle 10 -> no hilo_we, stallmd low from cycle 11, hi/lo unchanged.
//     rst low at DIV cycle 5 -> all outputs 0 immediately.
//  6. Back-to-back: MULTU 0xFFFFFFFF*2 (hi=1, lo=0xFFFFFFFE), then DIVU 9/4 starting the cycle after DONE
//     -> lo=2, hi=1; exactly one hilo_we per op; startE during DONE starts nothing.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// E-stage <-> HI/LO multiply/divide scheduler bundle: op request, stall and result write-back.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             flushE;
  logic             stallmd;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output startE, opE, srcaE, srcbE, flushE,
    input  stallmd, hilo_we, hi_o, lo_o
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, flushE,
    output stallmd, hilo_we, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO mul/div scheduler: MULT/MULTU in MUL_LAT+1 cycles, DIV/DIVU (radix-2 restoring) in WIDTH+1 cycles.
// Backpressure: stallmd freezes the pipeline from the accepting cycle until the one-cycle HI/LO write.
module muldiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  muldiv_ctrl_if.slave md
);

  localparam int CW = $clog2(((WIDTH > MUL_LAT) ? WIDTH : MUL_LAT) + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, nextState;
  logic [CW-1:0]    cnt;
  logic [1:0]       opReg;
  logic [WIDTH-1:0] aReg, bReg;
  logic [WIDTH:0]   remReg;
  logic [WIDTH-1:0] quoReg, dvsReg;
  logic [WIDTH-1:0] hiReg, loReg;
  logic             go, stallReq, writeHiLo, loadRes;

  logic             inSigned, regSigned;
  logic [WIDTH-1:0] srcaMag, srcbMag;
  logic [WIDTH:0]   shifted, diff, remNext;
  logic [WIDTH-1:0] quoNext, divHi, divLo, resHi, resLo;
  logic [2*WIDTH-1:0] prodA, prodB, product;

  // Operand magnitudes are taken at accept time so the divider loop itself is sign-agnostic.
  always_comb begin
    inSigned = ~md.opE[0];
    srcaMag  = (inSigned && md.srcaE[WIDTH-1]) ? -md.srcaE : md.srcaE;
    srcbMag  = (inSigned && md.srcbE[WIDTH-1]) ? -md.srcbE : md.srcbE;
  end

  always_comb begin
    regSigned = ~opReg[0];
    shifted   = {remReg[WIDTH-1:0], quoReg[WIDTH-1]};
    diff      = shifted - {1'b0, dvsReg};
    if (!diff[WIDTH]) begin
      remNext = diff;
      quoNext = {quoReg[WIDTH-2:0], 1'b1};
    end else begin
      remNext = shifted;
      quoNext = {quoReg[WIDTH-2:0], 1'b0};
    end

    // Result is formed from the final iteration's next values so HI/LO load on DONE entry.
    if (bReg == '0) begin
      divHi = aReg;
      divLo = '1;
    end else begin
      divHi = (regSigned && aReg[WIDTH-1]) ? -remNext[WIDTH-1:0] : remNext[WIDTH-1:0];
      divLo = (regSigned && (aReg[WIDTH-1] ^ bReg[WIDTH-1])) ? -quoNext : quoNext;
    end

    prodA   = {{WIDTH{regSigned & aReg[WIDTH-1]}}, aReg};
    prodB   = {{WIDTH{regSigned & bReg[WIDTH-1]}}, bReg};
    product = prodA * prodB;

    resHi = opReg[1] ? divHi : product[2*WIDTH-1:WIDTH];
    resLo = opReg[1] ? divLo : product[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    stallReq  = 1'b0;
    writeHiLo = 1'b0;
    go        = 1'b0;
    case (state)
      IDLE: begin
        go       = md.startE & ~md.flushE & rst;
        stallReq = go;
        if (go) nextState = md.opE[1] ? DIV : MUL;
      end
      MUL: begin
        stallReq = 1'b1;
        if (md.flushE)           nextState = IDLE;
        else if (cnt == MUL_LAST) nextState = DONE;
      end
      DIV: begin
        stallReq = 1'b1;
        if (md.flushE)           nextState = IDLE;
        else if (cnt == DIV_LAST) nextState = DONE;
      end
      DONE: begin
        // Committed result: neither flushE nor startE can suppress or overlap this write.
        writeHiLo = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign loadRes = (state != DONE) && (nextState == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      opReg  <= '0;
      aReg   <= '0;
      bReg   <= '0;
      remReg <= '0;
      quoReg <= '0;
      dvsReg <= '0;
      hiReg  <= '0;
      loReg  <= '0;
    end else begin
      if (go) begin
        opReg  <= md.opE;
        aReg   <= md.srcaE;
        bReg   <= md.srcbE;
        cnt    <= '0;
        remReg <= '0;
        quoReg <= srcaMag;
        dvsReg <= srcbMag;
      end else if (state == MUL || state == DIV) begin
        cnt <= cnt + CW'(1);
      end
      if (state == DIV) begin
        remReg <= remNext;
        quoReg <= quoNext;
      end
      if (loadRes) begin
        hiReg <= resHi;
        loReg <= resLo;
      end
    end
  end

  assign md.stallmd = stallReq;
  assign md.hilo_we = writeHiLo;
  assign md.hi_o    = hiReg;
  assign md.lo_o    = loReg;

endmodule
